// File: rtl/vga_axi_pkg.sv
// Shared AXI encodings for the VGA framebuffer read path and the ping-pong buffer.
// Holds the burst/size/response codes and the read-slave state type.
package vga_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B     = 3'h3;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_BURST = 1'b1
  } rd_state_e;

  function automatic logic resp_is_okay(input logic [1:0] resp);
    return (resp == AXI_RESP_OKAY);
  endfunction

endpackage

// File: rtl/vga_rd_beat_fifo.sv
// Two-entry beat FIFO; the head entry is read straight from storage registers
// so the AXI R outputs hold steady while the initiator stalls.
module vga_rd_beat_fifo #(
  parameter int W = 67
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] mem_r [2];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   count_r;
  logic         valid_r;
  logic         pop_ok_s;
  logic [1:0]   count_s;

  // Next occupancy from this cycle's push/pop.
  always_comb begin
    pop_ok_s = pop & valid_r;
    count_s  = count_r;
    case ({push, pop_ok_s})
      2'b10:   count_s = count_r + 2'd1;
      2'b01:   count_s = count_r - 2'd1;
      default: count_s = count_r;
    endcase
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0] <= {W{1'b0}};
      mem_r[1] <= {W{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
      valid_r  <= 1'b0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= wdata;
      end
      wr_ptr_r <= wr_ptr_r ^ push;
      rd_ptr_r <= rd_ptr_r ^ pop_ok_s;
      count_r  <= count_s;
      valid_r  <= (count_s != 2'd0);
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign valid = valid_r;
  assign count = count_r;

endmodule

// File: rtl/vga_fb_axi_rd_slave.sv
// AXI4 INCR read slave serving 8-byte words from a synchronous framebuffer SRAM.
// Bursts are classified once at AR time; error bursts emit zero beats with identical timing.
module vga_fb_axi_rd_slave #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_AW     = 12
) (
  input  logic                  clk_a,
  input  logic                  resetn_a,
  input  logic [ADDR_WIDTH-1:0] araddr_i,
  input  logic [1:0]            arburst_i,
  input  logic [7:0]            arlen_i,
  input  logic [2:0]            arsize_i,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rlast_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic                  mem_en_o,
  output logic [MEM_AW-1:0]     mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  import vga_axi_pkg::*;

  localparam int WORD_W = ADDR_WIDTH - 3;
  localparam int SUM_W  = ((WORD_W > MEM_AW) ? WORD_W : MEM_AW) + 9;
  localparam int FW     = DATA_WIDTH + 3;
  localparam logic [SUM_W-1:0] MEM_WORDS = {{(SUM_W-1){1'b0}}, 1'b1} << MEM_AW;

  rd_state_e         state_r;
  rd_state_e         state_s;
  logic              arready_r;
  logic [MEM_AW-1:0] addr_r;
  logic [8:0]        left_r;
  logic [1:0]        resp_r;
  logic              inflight_r;
  logic              inflight_last_r;

  logic              hs_s;
  logic              pop_s;
  logic              issue_s;
  logic [2:0]        credit_s;
  logic [1:0]        resp_s;
  logic [SUM_W-1:0]  end_word_s;
  logic [FW-1:0]     push_data_s;
  logic [FW-1:0]     head_s;
  logic              head_valid_s;
  logic [1:0]        count_s;

  // Burst classification; the end-word sum is widened so it cannot wrap.
  always_comb begin
    end_word_s = SUM_W'(araddr_i[ADDR_WIDTH-1:3]) + SUM_W'(arlen_i);
    resp_s     = AXI_RESP_OKAY;
    if ((arburst_i != AXI_BURST_INCR) || (arsize_i != AXI_SIZE_8B) || (araddr_i[2:0] != 3'b000)) begin
      resp_s = AXI_RESP_SLVERR;
    end else if (end_word_s >= MEM_WORDS) begin
      resp_s = AXI_RESP_DECERR;
    end else begin
      resp_s = AXI_RESP_OKAY;
    end
  end

  // Issue credit counts queued beats plus the one read whose data lands this cycle.
  always_comb begin
    hs_s     = arvalid_i & arready_r;
    pop_s    = head_valid_s & rready_i;
    credit_s = {1'b0, count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    issue_s  = 1'b0;
    if ((state_r == RD_BURST) && (left_r != 9'd0) && (credit_s < 3'd2)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Next-state: the burst ends once its last beat is handed over.
  always_comb begin
    state_s = state_r;
    case (state_r)
      RD_IDLE: begin
        if (hs_s) begin
          state_s = RD_BURST;
        end else begin
          state_s = RD_IDLE;
        end
      end
      RD_BURST: begin
        if (pop_s && head_s[0]) begin
          state_s = RD_IDLE;
        end else begin
          state_s = RD_BURST;
        end
      end
      default: state_s = RD_IDLE;
    endcase
  end

  // Burst bookkeeping and the one-deep SRAM read pipeline.
  always_ff @(posedge clk_a or negedge resetn_a) begin
    if (!resetn_a) begin
      state_r         <= RD_IDLE;
      arready_r       <= 1'b0;
      addr_r          <= {MEM_AW{1'b0}};
      left_r          <= 9'd0;
      resp_r          <= AXI_RESP_OKAY;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      arready_r <= (state_s == RD_IDLE);
      if (hs_s) begin
        addr_r <= araddr_i[MEM_AW+2:3];
        left_r <= {1'b0, arlen_i} + 9'd1;
        resp_r <= resp_s;
      end else if (issue_s) begin
        addr_r <= addr_r + {{(MEM_AW-1){1'b0}}, 1'b1};
        left_r <= left_r - 9'd1;
      end
      inflight_r      <= issue_s;
      inflight_last_r <= issue_s & (left_r == 9'd1);
    end
  end

  assign push_data_s = {(resp_is_okay(resp_r) ? mem_rdata_i : {DATA_WIDTH{1'b0}}), resp_r, inflight_last_r};

  vga_rd_beat_fifo #(
    .W(FW)
  ) u_beat_fifo (
    .clk  (clk_a),
    .rst_n(resetn_a),
    .push (inflight_r),
    .wdata(push_data_s),
    .pop  (pop_s),
    .head (head_s),
    .valid(head_valid_s),
    .count(count_s)
  );

  assign arready_o  = arready_r;
  assign mem_en_o   = issue_s & resp_is_okay(resp_r);
  assign mem_addr_o = addr_r;
  assign rvalid_o   = head_valid_s;
  assign rdata_o    = head_s[FW-1:3];
  assign rresp_o    = head_s[2:1];
  assign rlast_o    = head_s[0];

endmodule

// File: tb/tb_vga_fb_axi_rd_slave.sv
// Self-checking bench: randomized bursts against a behavioural model of the
// framebuffer read slave (word array plus response rules in plain arithmetic).
module tb_vga_fb_axi_rd_slave;

  logic        clk_a = 1'b0;
  logic        resetn_a;
  logic [63:0] araddr;
  logic [1:0]  arburst;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready_o;
  logic [63:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rlast_o;
  logic        rvalid_o;
  logic        rready;
  logic        mem_en_o;
  logic [11:0] mem_addr_o;
  logic [63:0] mem_rdata;

  always #5 clk_a = ~clk_a;

  vga_fb_axi_rd_slave #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .MEM_AW(12)) dut (
    .clk_a(clk_a), .resetn_a(resetn_a),
    .araddr_i(araddr), .arburst_i(arburst), .arlen_i(arlen), .arsize_i(arsize),
    .arvalid_i(arvalid), .arready_o(arready_o),
    .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o), .rvalid_o(rvalid_o), .rready_i(rready),
    .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata)
  );

  logic [63:0] mem_model [4096];
  always @(posedge clk_a) if (mem_en_o) mem_rdata <= mem_model[mem_addr_o];

  int cyc = 0;
  always @(posedge clk_a) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  logic [63:0] obs_data[$];
  logic [1:0]  obs_resp[$];
  logic        obs_last[$];
  int          obs_cyc[$];
  logic [11:0] en_addr[$];
  int          en_cyc[$];
  int          t_hs, ar_wait, stable_err;
  bit          timeout, arready_busy, arready_after;

  function automatic logic [1:0] ref_resp(logic [63:0] a, logic [7:0] l, logic [1:0] b, logic [2:0] s);
    if (b != 2'd1 || s != 3'd3 || a[2:0] != 3'd0) return 2'b10;
    if ((a >> 3) + 64'(l) >= 64'd4096) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic pick_rready(int rmode, int i);
    if (rmode == 1) return ((i % 2 == 1 && i < 8) || (i >= 12 && i < 22)) ? 1'b0 : 1'b1;
    if (rmode == 2) return ($urandom_range(0, 3) != 0);
    return 1'b1;
  endfunction

  // Drives one AR and collects every R handshake and SRAM read until rlast (bounded).
  task automatic do_burst(input logic [63:0] a, input logic [7:0] l, input logic [1:0] b,
                          input logic [2:0] s, input int rmode, input bit hold_ar);
    int i = 0;
    bit done = 0;
    bit prev_stall = 0;
    logic [66:0] prev = '0;
    obs_data.delete(); obs_resp.delete(); obs_last.delete(); obs_cyc.delete();
    en_addr.delete(); en_cyc.delete();
    timeout = 0; stable_err = 0; arready_busy = 0; ar_wait = 0;
    @(negedge clk_a);
    araddr = a; arlen = l; arburst = b; arsize = s; arvalid = 1'b1; rready = 1'b0;
    #1;
    while (!arready_o && ar_wait < 100) begin
      @(negedge clk_a); ar_wait++; #1;
    end
    if (!arready_o) begin
      timeout = 1; arvalid = 1'b0;
      return;
    end
    t_hs = cyc;
    @(negedge clk_a);
    if (hold_ar) araddr = a + 64'h40;
    else arvalid = 1'b0;
    while (!done && i < 2000) begin
      rready = pick_rready(rmode, i);
      #1;
      if (mem_en_o) begin en_addr.push_back(mem_addr_o); en_cyc.push_back(cyc - t_hs); end
      if (arready_o) arready_busy = 1;
      if (rvalid_o) begin
        if (prev_stall && {rdata_o, rresp_o, rlast_o} !== prev) stable_err++;
        prev = {rdata_o, rresp_o, rlast_o};
        prev_stall = !rready;
        if (rready) begin
          obs_data.push_back(rdata_o); obs_resp.push_back(rresp_o);
          obs_last.push_back(rlast_o); obs_cyc.push_back(cyc - t_hs);
          if (rlast_o) done = 1;
        end
      end else begin
        if (prev_stall) stable_err++;
        prev_stall = 0;
      end
      i++;
      @(negedge clk_a);
    end
    arvalid = 1'b0; rready = 1'b0;
    #1;
    arready_after = arready_o;
    if (!done) timeout = 1;
  endtask

  task automatic test_reset();
    resetn_a = 1'b0; arvalid = 1'b0; araddr = '0; arlen = '0; arburst = 2'd1; arsize = 3'd3; rready = 1'b0;
    repeat (3) @(negedge clk_a);
    #1;
    n_cmp++;
    if ({arready_o, rvalid_o, rlast_o, rresp_o, rdata_o, mem_en_o, mem_addr_o} !== 80'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got arready=%b rvalid=%b rlast=%b rresp=%h rdata=%h mem_en=%b mem_addr=%h, expected all zero",
               arready_o, rvalid_o, rlast_o, rresp_o, rdata_o, mem_en_o, mem_addr_o);
    end
    @(negedge clk_a); resetn_a = 1'b1; #1;
    n_cmp++;
    if (arready_o !== 1'b0) begin n_fail++; $display("FAIL reset_arready_before_clk: got %b expected 0", arready_o); end
    @(negedge clk_a); #1;
    n_cmp++;
    if (arready_o !== 1'b1) begin n_fail++; $display("FAIL reset_arready_after_clk: got %b expected 1", arready_o); end
  endtask

  task automatic test_incr_basic();
    do_burst(64'h100, 8'd31, 2'b01, 3'd3, 0, 0);
    n_cmp++;
    if (timeout || obs_data.size() != 32) begin
      n_fail++; $display("FAIL incr_beat_count: got %0d (timeout=%0b) expected 32", obs_data.size(), timeout);
    end
    for (int k = 0; k < obs_data.size() && k < 32; k++) begin
      n_cmp++;
      if ({obs_data[k], obs_resp[k], obs_last[k], 32'(obs_cyc[k])} !== {mem_model[32 + k], 2'b00, (k == 31), 32'(3 + k)}) begin
        n_fail++;
        $display("FAIL incr_beat[%0d]: got data=%h resp=%h last=%b cyc=T+%0d expected data=%h resp=0 last=%b cyc=T+%0d",
                 k, obs_data[k], obs_resp[k], obs_last[k], obs_cyc[k], mem_model[32 + k], (k == 31), 3 + k);
      end
    end
    n_cmp++;
    if (en_addr.size() != 32 || en_cyc[0] != 1) begin
      n_fail++; $display("FAIL incr_mem_en: got %0d reads expected 32 starting at T+1", en_addr.size());
    end
    for (int k = 0; k < en_addr.size() && k < 32; k++) begin
      n_cmp++;
      if (en_addr[k] !== 12'(32 + k)) begin
        n_fail++; $display("FAIL incr_mem_addr[%0d]: got %h expected %h", k, en_addr[k], 12'(32 + k));
      end
    end
    n_cmp++;
    if ({arready_busy, arready_after} !== 2'b01) begin
      n_fail++; $display("FAIL incr_arready: got busy=%b after=%b expected busy=0 after=1", arready_busy, arready_after);
    end
  endtask

  task automatic test_backpressure();
    do_burst(64'h100, 8'd31, 2'b01, 3'd3, 1, 0);
    n_cmp++;
    if (timeout || obs_data.size() != 32 || stable_err != 0) begin
      n_fail++; $display("FAIL bp_count_stable: got beats=%0d unstable=%0d expected beats=32 unstable=0", obs_data.size(), stable_err);
    end
    for (int k = 0; k < obs_data.size() && k < 32; k++) begin
      n_cmp++;
      if ({obs_data[k], obs_resp[k], obs_last[k]} !== {mem_model[32 + k], 2'b00, (k == 31)}) begin
        n_fail++; $display("FAIL bp_beat[%0d]: got %h/%h/%b expected %h/0/%b", k, obs_data[k], obs_resp[k], obs_last[k], mem_model[32 + k], (k == 31));
      end
    end
  endtask

  task automatic test_errors();
    logic [63:0] ea [5] = '{64'h100, 64'h200, 64'h104, 64'h7FF8, 64'hFFFF_FFFF_FFFF_FFF8};
    logic [1:0]  eb [5] = '{2'd2, 2'd1, 2'd1, 2'd1, 2'd1};
    logic [2:0]  es [5] = '{3'd3, 3'd2, 3'd3, 3'd3, 3'd3};
    logic [7:0]  el [5] = '{8'd3, 8'd2, 8'd1, 8'd1, 8'd255};
    logic [1:0]  er [5] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
    for (int t = 0; t < 5; t++) begin
      do_burst(ea[t], el[t], eb[t], es[t], (t == 4) ? 2 : 0, 0);
      n_cmp++;
      if (timeout || obs_data.size() != int'(el[t]) + 1 || en_addr.size() != 0) begin
        n_fail++; $display("FAIL err%0d_count: got beats=%0d reads=%0d expected beats=%0d reads=0", t, obs_data.size(), en_addr.size(), int'(el[t]) + 1);
      end
      if (t < 4 && obs_cyc.size() > 0) begin
        n_cmp++;
        if (obs_cyc[0] != 3) begin n_fail++; $display("FAIL err%0d_latency: got T+%0d expected T+3", t, obs_cyc[0]); end
      end
      for (int k = 0; k < obs_data.size(); k++) begin
        n_cmp++;
        if ({obs_data[k], obs_resp[k], obs_last[k]} !== {64'd0, er[t], (k == int'(el[t]))}) begin
          n_fail++; $display("FAIL err%0d_beat[%0d]: got %h/%h/%b expected 0/%h/%b", t, k, obs_data[k], obs_resp[k], obs_last[k], er[t], (k == int'(el[t])));
        end
      end
    end
    do_burst(64'd4094 * 64'd8, 8'd1, 2'b01, 3'd3, 0, 0);
    n_cmp++;
    if (timeout || obs_data.size() != 2 || en_addr.size() != 2) begin
      n_fail++; $display("FAIL edge_ok_count: got beats=%0d reads=%0d expected 2/2", obs_data.size(), en_addr.size());
    end else begin
      n_cmp++;
      if ({obs_data[0], obs_resp[0], obs_last[0], obs_data[1], obs_resp[1], obs_last[1]} !==
          {mem_model[4094], 2'b00, 1'b0, mem_model[4095], 2'b00, 1'b1}) begin
        n_fail++; $display("FAIL edge_ok_beats: got %h/%h %h/%h expected %h/0 %h/0", obs_data[0], obs_resp[0], obs_data[1], obs_resp[1], mem_model[4094], mem_model[4095]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a;
    logic [7:0]  l;
    for (int t = 0; t < 5; t++) begin
      a = 64'($urandom_range(0, 3000)) * 64'd8;
      l = (t == 0) ? 8'd0 : 8'($urandom_range(0, 6));
      do_burst(a, l, 2'b01, 3'd3, 2, 1);
      n_cmp++;
      if (timeout || obs_data.size() != int'(l) + 1 || ar_wait != 0 || arready_busy || !arready_after) begin
        n_fail++;
        $display("FAIL b2b%0d: got beats=%0d ar_wait=%0d busy=%b after=%b expected beats=%0d ar_wait=0 busy=0 after=1",
                 t, obs_data.size(), ar_wait, arready_busy, arready_after, int'(l) + 1);
      end
      for (int k = 0; k < obs_data.size(); k++) begin
        n_cmp++;
        if ({obs_data[k], obs_resp[k], obs_last[k]} !== {mem_model[(a >> 3) + 64'(k)], 2'b00, (k == int'(l))}) begin
          n_fail++; $display("FAIL b2b%0d_beat[%0d]: got %h/%h/%b expected %h/0/%b", t, k, obs_data[k], obs_resp[k], obs_last[k], mem_model[(a >> 3) + 64'(k)], (k == int'(l)));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] a;
    logic [7:0]  l;
    logic [1:0]  b, r;
    logic [2:0]  s;
    int sel;
    for (int t = 0; t < 30; t++) begin
      sel = $urandom_range(0, 9);
      a = 64'($urandom_range(0, 4095)) * 64'd8;
      l = (t == 7) ? 8'd255 : 8'($urandom_range(0, 40));
      b = 2'd1; s = 3'd3;
      if (sel == 0) a = a + 64'($urandom_range(1, 7));
      if (sel == 1) b = 2'($urandom_range(0, 3));
      if (sel == 2) s = 3'($urandom_range(0, 7));
      if (sel == 3) a = {32'($urandom), 32'($urandom)} & ~64'h7;
      r = ref_resp(a, l, b, s);
      do_burst(a, l, b, s, 2, 0);
      n_cmp++;
      if (timeout || obs_data.size() != int'(l) + 1 || stable_err != 0 || arready_busy || !arready_after) begin
        n_fail++;
        $display("FAIL rnd%0d_burst: got beats=%0d unstable=%0d busy=%b after=%b expected beats=%0d", t, obs_data.size(), stable_err, arready_busy, arready_after, int'(l) + 1);
      end
      n_cmp++;
      if (en_addr.size() != ((r == 2'b00) ? int'(l) + 1 : 0)) begin
        n_fail++; $display("FAIL rnd%0d_reads: got %0d expected %0d", t, en_addr.size(), (r == 2'b00) ? int'(l) + 1 : 0);
      end
      for (int k = 0; k < obs_data.size(); k++) begin
        n_cmp++;
        if ({obs_data[k], obs_resp[k], obs_last[k]} !==
            {((r == 2'b00) ? mem_model[12'((a >> 3) + 64'(k))] : 64'd0), r, (k == int'(l))}) begin
          n_fail++; $display("FAIL rnd%0d_beat[%0d]: got %h/%h/%b expected resp %h last %b", t, k, obs_data[k], obs_resp[k], obs_last[k], r, (k == int'(l)));
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int beats = 0;
    int guard = 0;
    int seen = 0;
    @(negedge clk_a);
    araddr = 64'h100; arlen = 8'd31; arburst = 2'd1; arsize = 3'd3; arvalid = 1'b1; rready = 1'b1;
    #1;
    n_cmp++;
    if (arready_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ar: got arready=%b expected 1", arready_o); end
    @(negedge clk_a); arvalid = 1'b0;
    while (beats < 10 && guard < 200) begin
      #1;
      if (rvalid_o && rready) beats++;
      guard++;
      @(negedge clk_a);
    end
    resetn_a = 1'b0;
    #1;
    n_cmp++;
    if ({beats == 10, rvalid_o, mem_en_o, arready_o, rlast_o} !== 5'b10000) begin
      n_fail++; $display("FAIL rst_mid_drop: got beats=%0d rvalid=%b mem_en=%b arready=%b expected beats=10 and all low", beats, rvalid_o, mem_en_o, arready_o);
    end
    repeat (3) begin @(negedge clk_a); #1; if (rvalid_o) seen++; end
    resetn_a = 1'b1;
    repeat (3) begin @(negedge clk_a); #1; if (rvalid_o) seen++; end
    n_cmp++;
    if (seen != 0 || arready_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_after: got stray_beats=%0d arready=%b expected 0 and 1", seen, arready_o);
    end
    do_burst(64'h0, 8'd3, 2'b01, 3'd3, 0, 0);
    n_cmp++;
    if (timeout || obs_data.size() != 4) begin
      n_fail++; $display("FAIL rst_new_count: got %0d expected 4", obs_data.size());
    end else begin
      n_cmp++;
      if ({obs_data[0], obs_resp[0], obs_data[3], obs_last[3]} !== {mem_model[0], 2'b00, mem_model[3], 1'b1}) begin
        n_fail++; $display("FAIL rst_new_data: got first=%h last=%h expected first=%h last=%h", obs_data[0], obs_data[3], mem_model[0], mem_model[3]);
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem_model[i] = {32'($urandom), 32'($urandom)};
    mem_rdata = '0;
    test_reset();
    test_incr_basic();
    test_backpressure();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
